// File: rtl/ifmap_feeder_pkg.sv
// Shared types and sizing helpers for the systolic ifmap skew feeder.
package ifmap_feeder_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  function automatic int flush_cnt_w(input int rows);
    return $clog2(rows + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered occupancy count.
// full/empty derive only from the count register, so there is no combinational path from pop to full.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0] ONE      = (PW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full && !clear;
  assign do_pop   = pop && !empty && !clear;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ifmap_skew_feeder.sv
// Left-edge ifmap feeder: buffers input vectors, applies per-lane systolic skew and drains each tile with zeros.
module ifmap_skew_feeder
  import ifmap_feeder_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int DEPTH  = 8,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [ROWS*DATA_W-1:0] s_data,
  input  logic                   s_last,
  input  logic                   stall,
  output logic [ROWS*DATA_W-1:0] arr_ifmap,
  output logic [ROWS-1:0]        arr_lane_vld,
  output logic                   busy,
  output logic                   tile_done
);

  localparam int VW    = ROWS * DATA_W;
  localparam int CNT_W = flush_cnt_w(ROWS);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ROWS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             done_n;
  logic             full, empty;
  logic             push, pop;
  logic [VW:0]      pop_data;
  logic             pop_last;
  logic [VW-1:0]    pop_vec;

  assign s_ready  = !full;
  assign push     = s_valid && s_ready;
  assign pop      = !clear && !stall && !empty && (state == IDLE || state == STREAM);
  assign pop_last = pop_data[VW];
  assign pop_vec  = pop_data[VW-1:0];
  assign busy     = (state != IDLE) || !empty;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (VW + 1)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .push      (push),
    .push_data ({s_last, s_data}),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      tile_done <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      cnt       <= '0;
      tile_done <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      tile_done <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    done_n  = 1'b0;
    case (state)
      IDLE, STREAM: begin
        if (pop) begin
          if (pop_last) begin
            state_n = FLUSH;
            cnt_n   = CNT_INIT;
          end else begin
            state_n = STREAM;
          end
        end
      end
      FLUSH: begin
        // One zero column per non-stalled edge until the deepest lane has emptied.
        if (!stall) begin
          cnt_n = cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [r:0][DATA_W-1:0] d_q;
    logic [r:0]             v_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        d_q <= '0;
        v_q <= '0;
      end else if (clear) begin
        d_q <= '0;
        v_q <= '0;
      end else if (!stall) begin
        d_q[0] <= pop ? pop_vec[r*DATA_W +: DATA_W] : '0;
        v_q[0] <= pop;
        for (int i = 1; i <= r; i++) begin
          d_q[i] <= d_q[i-1];
          v_q[i] <= v_q[i-1];
        end
      end
    end

    assign arr_ifmap[r*DATA_W +: DATA_W] = d_q[r];
    assign arr_lane_vld[r]               = v_q[r];
  end

endmodule
